// File: rtl/tb_irq_trap_monitor.sv
// Interrupt generator and end-of-test monitor for the picorv32 harness.
// A private cycle counter drives IRQ_CH periodic interrupt channels (pulse or
// sticky with EOI clear). The monitor watches trap, drains TRAP_DELAY cycles
// and then reports pass/fail or timeout, freezing the counters.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   run              core released from reset; enables counting
//   irq_en           per-channel enable
//   irq_eoi          end-of-interrupt from core; clears sticky bits
//   trap             core trap
//   tests_passed     pass flag from the memory model
//   irq              registered interrupt vector to the core
//   cycle_count      cycles since run was asserted
//   done             verdict valid; sticky until reset
//   pass             tests_passed sampled at end of drain
//   timeout          TIMEOUT reached before trap
//   trap_cycle       cycle_count value on the cycle trap was first seen
module tb_irq_trap_monitor #(
  parameter int unsigned          NUM_IRQ        = 32,
  parameter int unsigned          CNT_W          = 32,
  parameter int unsigned          IRQ_CH         = 2,
  parameter logic [5*IRQ_CH-1:0]  CH_IRQ_IDX     = {5'd5, 5'd4},
  parameter logic [5*IRQ_CH-1:0]  CH_LOG2_PERIOD = {5'd16, 5'd13},
  parameter logic [IRQ_CH-1:0]    CH_STICKY      = 2'b00,
  parameter int unsigned          TRAP_DELAY     = 10,
  parameter int unsigned          TIMEOUT        = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [IRQ_CH-1:0]  irq_en,
  input  logic [NUM_IRQ-1:0] irq_eoi,
  input  logic               trap,
  input  logic               tests_passed,
  output logic [NUM_IRQ-1:0] irq,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [CNT_W-1:0]   trap_cycle
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned DRAIN_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // A bit holds until EOI if any channel mapped onto it is sticky.
  function automatic logic [NUM_IRQ-1:0] sticky_bits();
    logic [NUM_IRQ-1:0] m;
    m = '0;
    for (int i = 0; i < int'(IRQ_CH); i++) begin
      if (CH_STICKY[i]) m[CH_IRQ_IDX[IDX_W*i +: IDX_W]] = 1'b1;
    end
    return m;
  endfunction

  // Low k bits set; k == 0 gives an empty mask, so the channel fires every cycle.
  function automatic logic [CNT_W-1:0] period_mask(input logic [IDX_W-1:0] k);
    return (CNT_W'(1) << k) - CNT_W'(1);
  endfunction

  localparam logic [NUM_IRQ-1:0] STICKY_MASK = sticky_bits();

  // Reject channel maps and drain lengths the hardware cannot honour.
  for (genvar g = 0; g < int'(IRQ_CH); g++) begin : g_chk
    if (32'(CH_LOG2_PERIOD[IDX_W*g +: IDX_W]) > CNT_W) begin : g_bad_k
      $error("channel period exponent exceeds counter width");
    end
    if (32'(CH_IRQ_IDX[IDX_W*g +: IDX_W]) >= NUM_IRQ) begin : g_bad_idx
      $error("channel irq index out of range");
    end
  end
  if (TRAP_DELAY == 0 || TRAP_DELAY > 255) begin : g_bad_delay
    $error("TRAP_DELAY must be 1..255");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     trap_cycle_q, trap_cycle_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [NUM_IRQ-1:0]   irq_q, irq_d;
  logic [NUM_IRQ-1:0]   fire;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 active_q;
  logic                 timeout_hit;
  logic                 drain_last;

  assign active_q    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign drain_last  = (drain_q == DRAIN_W'(TRAP_DELAY - 1));

  // Run-state FSM; the counter is held on the cycle that enters DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    trap_cycle_d = trap_cycle_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        drain_d = '0;
        if (run) state_d = S_RUN;
      end
      S_RUN: begin
        if (!run) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          drain_d      = '0;
          trap_cycle_d = '0;
        end else if (trap) begin
          state_d      = S_DRAIN;
          trap_cycle_d = cnt_q;
          cnt_d        = cnt_q + CNT_W'(1);
          drain_d      = '0;
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!run) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          drain_d      = '0;
          trap_cycle_d = '0;
        end else if (drain_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = tests_passed;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-bit fire vector; channels sharing an index are ORed.
  always_comb begin
    fire = '0;
    if (active_q) begin
      for (int i = 0; i < int'(IRQ_CH); i++) begin
        if (irq_en[i] &&
            ((cnt_q & period_mask(CH_LOG2_PERIOD[IDX_W*i +: IDX_W])) ==
             period_mask(CH_LOG2_PERIOD[IDX_W*i +: IDX_W])))
          fire[CH_IRQ_IDX[IDX_W*i +: IDX_W]] = 1'b1;
      end
    end
  end

  // Set beats EOI; leaving RUN/DRAIN clears everything.
  always_comb begin
    irq_d = '0;
    if (state_d == S_RUN || state_d == S_DRAIN)
      irq_d = fire | (STICKY_MASK & irq_q & ~irq_eoi);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      trap_cycle_q <= '0;
      irq_q        <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      trap_cycle_q <= trap_cycle_d;
      irq_q        <= irq_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign irq         = irq_q;
  assign cycle_count = cnt_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign trap_cycle  = trap_cycle_q;

endmodule

// File: doc/tb_irq_trap_monitor.md
Name: tb_irq_trap_monitor

Overview:
- Parametrised interrupt generator plus end-of-test monitor for the picorv32 simulation harness.
- Drives the core's irq vector from a private cycle counter; each of IRQ_CH channels supports a power-of-two period, pulse or sticky mode, and end-of-interrupt clearing.
- Watches trap, drains TRAP_DELAY cycles, then reports pass, fail or timeout together with the trap cycle.
- Synthesisable; sits beside the core and AXI memory model.

Parameters:
- NUM_IRQ, 32, width of the irq and irq_eoi vectors.
- CNT_W, 32, width of the cycle counter and trap_cycle.
- IRQ_CH, 2, number of interrupt channels.
- CH_IRQ_IDX, {5'd5,5'd4}, packed 5 bits per channel: irq bit driven by channel i, taken from bits [5i+4:5i].
- CH_LOG2_PERIOD, {5'd16,5'd13}, packed 5 bits per channel: K_i; channel fires when cnt[K_i-1:0] is all ones; K_i=0 fires every cycle.
- CH_STICKY, 2'b00, per channel: 0 = one-cycle pulse, 1 = hold until EOI.
- TRAP_DELAY, 10, drain cycles after trap before the verdict; range 1..255.
- TIMEOUT, 0, cycle limit for a run; 0 disables the limit.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  core released from reset; enables counting.
- irq_en  in  IRQ_CH  per-channel enable.
- irq_eoi  in  NUM_IRQ  end-of-interrupt from core; clears sticky bits.
- trap  in  1  core trap.
- tests_passed  in  1  pass flag from the memory model.
- irq  out  NUM_IRQ  registered interrupt vector to the core.
- cycle_count  out  CNT_W  cycles since run was asserted.
- done  out  1  verdict valid; sticky until reset.
- pass  out  1  tests_passed sampled at end of drain.
- timeout  out  1  TIMEOUT reached before trap.
- trap_cycle  out  CNT_W  cycle_count value on the cycle trap was first seen.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, cnt=0, drain counter=0.
- FSM states:
  - IDLE: cnt held at 0. Moves to RUN on run=1.
  - RUN: cnt increments every cycle and wraps at 2^CNT_W.
    - trap=1: latch trap_cycle<=cnt, go to DRAIN.
    - Else, if TIMEOUT!=0 and cnt==TIMEOUT-1: go to DONE with timeout=1, pass=0.
    - trap and timeout in the same cycle: trap wins.
  - DRAIN: cnt keeps counting; drain counter counts 0..TRAP_DELAY-1. On the final count: pass<=tests_passed, go to DONE. Later trap edges are ignored.
  - DONE: done=1; cnt, pass, timeout and trap_cycle frozen; irq forced to 0. Leaves only on reset; run deassertion is ignored.
- run=0 in RUN or DRAIN: synchronous return to IDLE; cnt, drain counter, trap_cycle and irq cleared; done stays 0.
- Interrupt generation, active only in RUN or DRAIN:
  - fire_i = irq_en[i] & (&cnt[K_i-1:0]).
  - Pulse channel: irq[CH_IRQ_IDX_i] is high for exactly the one cycle after the cnt value that matched.
  - Sticky channel: bit set on fire. Cleared on the cycle after irq_eoi[idx]=1. Set wins over a simultaneous EOI.
  - Channels sharing an index are ORed; a bit is sticky if any contributing channel is sticky.
  - Bits not mapped by any channel are constant 0.
  - Clearing irq_en does not clear an already-set sticky bit.
- Latency: irq lags the matching cnt value by 1 cycle. done rises TRAP_DELAY+1 cycles after the cycle trap is sampled.
- cycle_count = cnt, registered.
- Elaboration errors: K_i > CNT_W, CH_IRQ_IDX_i >= NUM_IRQ, or TRAP_DELAY=0.

Test Plan:
- Defaults, run=1 at T0, irq_en=2'b11 -> irq[4] high only on cycles T0+8192, T0+16384, ...; irq[5] high at T0+65536; at T0+65536 both irq[4] and irq[5] high in the same cycle.
- CH_STICKY=2'b01, K0=3 -> irq[4] rises at T0+8 and stays high; irq_eoi[4] pulsed at T0+20 -> low at T0+21. EOI coincident with a fire at cnt=23 -> irq[4] stays high.
- trap pulsed when cnt=100, tests_passed=1 -> trap_cycle=100; done=1 and pass=1 exactly 11 cycles later; irq=0; cycle_count frozen at 110.
- Same with tests_passed=0 during drain -> done=1, pass=0, timeout=0. A second trap during drain leaves trap_cycle=100.
- TIMEOUT=500, no trap -> done=1, timeout=1, pass=0 after cnt=499. Trap at cnt=499 -> DRAIN instead, timeout=0.
- run dropped at cnt=50 during DRAIN -> IDLE, cycle_count=0, done=0. Re-raise run -> counting restarts from 0. Async reset asserted in DONE -> all outputs 0 immediately.
